// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder: sums BLOCK bits per clock with valid/ready handshakes.
// Optional CLA_SUB_EN adds the sub port for a - b - cin.
module cla_seq_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N = WIDTH / BLOCK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             accept, last;
    logic [BLOCK-1:0] a_sl, b_sl, g, p, sum;
    logic [BLOCK:0]   c;
    logic             pp;

`ifdef CLA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ^ cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign accept = in_valid && in_ready;
    assign last   = (k_q == KLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StRun;
            StRun:   if (last)      state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Single-level lookahead: every carry is a flat sum of g/p products back to the slice carry-in.
    always_comb begin
        a_sl = a_q[k_q*BLOCK +: BLOCK];
        b_sl = b_q[k_q*BLOCK +: BLOCK];
        g    = a_sl & b_sl;
        p    = a_sl ^ b_sl;
        pp   = 1'b0;
        c    = '0;
        c[0] = carry_q;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & carry_q);
        end
        sum = p ^ c[BLOCK-1:0];
    end

    always_comb begin
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b_eff;
            carry_d = cin_eff;
            k_d     = '0;
        end else if (state_q == StRun) begin
            s_d[k_q*BLOCK +: BLOCK] = sum;
            carry_d                 = c[BLOCK];
            if (last) begin
                cout_d = c[BLOCK];
                ovf_d  = c[BLOCK] ^ c[BLOCK-1];
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: 32/8 instance with random traffic, plus a 16/16 instance.
module tb_cla_seq_adder;

    localparam int N = 4;
`ifdef CLA_SUB_EN
    localparam bit SubEn = 1'b1;
`else
    localparam bit SubEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, s;
    logic        sub_v;
    logic        rand_rdy = 1'b0;
    logic        rdy_val = 1'b1;

    logic        in_valid16, in_ready16, cin16, out_valid16, cout16, ovf16;
    logic [15:0] a16, b16, s16;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        int          t;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;

`ifdef CLA_SUB_EN
    logic sub;
    assign sub = sub_v;
`endif

    cla_seq_adder #(.WIDTH(32), .BLOCK(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    cla_seq_adder #(.WIDTH(16), .BLOCK(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
`ifdef CLA_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid16),
        .out_ready (1'b1),
        .s         (s16),
        .cout      (cout16),
        .ovf       (ovf16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci,
                                   input logic sb, input int t);
        exp_t        e;
        logic [31:0] yy;
        logic        cc;
        logic [32:0] full;
        yy     = sb ? ~y : y;
        cc     = sb ? ~ci : ci;
        full   = {1'b0, x} + {1'b0, yy} + {32'd0, cc};
        e.s    = full[31:0];
        e.cout = full[32];
        e.ovf  = (x[31] == yy[31]) && (e.s[31] != x[31]);
        e.t    = t;
        return e;
    endfunction

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci,
                         input logic sb);
        logic rdy;
        rdy = 1'b0;
        @(negedge clk);
        a = x;
        b = y;
        cin = ci;
        sub_v = sb;
        in_valid = 1'b1;
        for (int w = 0; w < 60; w++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                #1;
                q.push_back(model(x, y, ci, sb && SubEn, cyc));
                in_valid = 1'b0;
                a = $urandom;
                b = $urandom;
                cin = 1'($urandom);
                sub_v = 1'($urandom);
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("accept_timeout", {63'd0, rdy}, 64'd1);
    endtask

    task automatic drain();
        for (int w = 0; w < 300; w++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
    endtask

    // Monitor: latency on each rising out_valid, result on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !prev_v) begin
                chk("valid_has_expect", {63'd0, q.size() != 0}, 64'd1);
                if (q.size() != 0) chk("latency", 64'(cyc - q[0].t), 64'(N));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("result", {30'd0, cout, ovf, s}, {30'd0, e.cout, e.ovf, e.s});
            end
        end
        prev_v = out_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          last_acc;
        int          n16;
        logic [17:0] e16[$];
        int          t16[$];
        logic [17:0] ee;
        logic [16:0] f16;
        logic        ok;

        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {28'd0, out_valid, cout, ovf, s}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;

        issue(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        drain();

        // Backpressure: result held while out_ready is low.
        rdy_val = 1'b0;
        repeat (2) @(negedge clk);
        issue(32'h1234_5670, 32'h8, 1'b0, 1'b0);
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            ok = out_valid;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {29'd0, out_valid, in_ready, cout, s}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h1234_5678});
            @(negedge clk);
        end
        rdy_val = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 10 && !ok; w++) begin
            @(negedge clk);
            ok = out_valid && out_ready;
        end
        @(negedge clk);
        chk("bp_release", {62'd0, in_ready, out_valid}, 64'd2);

        // Reset on the second RUN edge aborts the operation.
        issue(32'h0000_DEAD, 32'h0000_BEEF, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_state", {29'd0, in_ready, out_valid, cout, ovf, s}, {29'd0, 1'b1, 35'd0});
        repeat (N + 3) @(negedge clk);
        issue(32'd3, 32'd4, 1'b0, 1'b0);
        drain();

        if (SubEn) begin
            issue(32'd5, 32'd7, 1'b0, 1'b1);
            issue(32'h8000_0000, 32'd1, 1'b0, 1'b1);
            drain();
        end

        rand_rdy = 1'b1;
        issue(32'h0, 32'h0, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            issue($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        drain();
        rand_rdy = 1'b0;
        repeat (3) @(negedge clk);

        // N=1 instance: latency 1 and one accept every 3 cycles with out_ready tied high.
        last_acc = -1;
        n16 = 0;
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
        in_valid16 = 1'b1;
        for (int w = 0; w < 40 && n16 < 5; w++) begin
            @(negedge clk);
            if (out_valid16 && e16.size() != 0) begin
                ee = e16.pop_front();
                chk("result16", {46'd0, ovf16, cout16, s16}, {46'd0, ee});
                chk("latency16", 64'(cyc - t16.pop_front()), 64'd1);
                n16++;
            end
            if (in_ready16) begin
                f16 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
                e16.push_back({(a16[15] == b16[15]) && (f16[15] != a16[15]), f16});
                t16.push_back(cyc + 1);
                if (last_acc >= 0) chk("ii16", 64'(cyc + 1 - last_acc), 64'd3);
                last_acc = cyc + 1;
            end else begin
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                cin16 = 1'($urandom);
            end
        end
        in_valid16 = 1'b0;
        chk("count16", 64'(n16), 64'd5);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
